bcd_scan_display: RTL and testbench



---
 rtl/display_pkg.sv | 22 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/bcd_scan_display.sv | 107 ++++++++++
 tb/tb_bcd_scan_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {DEAD, SHOW} state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-decimal nibbles (A-F) decode to a dash so bad input stays visible.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 3-digit seven-segment driver with per-slot dead time and
// frame-synchronous input shadowing. Define LZ_BLANK_EN for leading-zero blanking.
module bcd_scan_display
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic [7:0]  ndigits,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel,
  output logic        frame_done,
  output state_t      dbg_state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_DEAD = CW'(DEAD);

  logic [CW-1:0] cyc, cyc_nxt;
  logic [1:0]    idx, idx_nxt;
  state_t        state, state_nxt;
  logic [11:0]   sh_bcd;
  logic [1:0]    sh_nd;
  logic          wrap;
  logic          frame_nxt;
  logic          show_nxt;
  logic          lz_blank;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  // Outputs are registered from next-cycle values so they line up with cyc.
  always_comb begin
    wrap      = (cyc == CYC_LAST);
    cyc_nxt   = wrap ? '0 : cyc + 1'b1;
    idx_nxt   = idx;
    if (wrap) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    frame_nxt = (cyc_nxt == CYC_LAST) && (idx_nxt == 2'd2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      display_pkg::DEAD: if (cyc_nxt == CYC_DEAD) state_nxt = SHOW;
      SHOW:              if (wrap) state_nxt = display_pkg::DEAD;
      default:           state_nxt = display_pkg::DEAD;
    endcase
  end

  always_comb begin
    nibble   = 4'd0;
    lz_blank = 1'b0;
    case (idx_nxt)
      2'd0:    nibble = sh_bcd[3:0];
      2'd1:    nibble = sh_bcd[7:4];
      2'd2:    nibble = sh_bcd[11:8];
      default: nibble = 4'd0;
    endcase
`ifdef LZ_BLANK_EN
    // A digit is a leading zero when it and every enabled digit above it are zero.
    case (idx_nxt)
      2'd1:    lz_blank = (sh_bcd[7:4] == 4'd0) && ((sh_bcd[11:8] == 4'd0) || (sh_nd < 2'd3));
      2'd2:    lz_blank = (sh_bcd[11:8] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
    show_nxt = (state_nxt == SHOW) && (idx_nxt < sh_nd) && !lz_blank;
  end

  bcd_to_seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= '0;
      idx        <= 2'd0;
      state      <= display_pkg::DEAD;
      sh_bcd     <= 12'd0;
      sh_nd      <= 2'd0;
      seg        <= SEG_BLANK;
      dig_sel    <= 3'b000;
      frame_done <= 1'b0;
    end else begin
      cyc        <= cyc_nxt;
      idx        <= idx_nxt;
      state      <= state_nxt;
      frame_done <= frame_nxt;
      seg        <= show_nxt ? seg_dec : SEG_BLANK;
      dig_sel    <= show_nxt ? (3'b001 << idx_nxt) : 3'b000;
      // Cycle 0 of every slot is dead, so the new shadow is never needed on the load edge.
      if (frame_done) begin
        sh_bcd <= bcd;
        sh_nd  <= (ndigits > 8'd3) ? 2'd3 : ndigits[1:0];
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: a frame-level reference model predicts
// every display cycle; a monitor compares DUT outputs on the falling edge.
module tb_bcd_scan_display;

  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = 3 * CLK_DIV;
  localparam int W       = 12;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd;
  logic [7:0]  ndigits;
  logic [6:0]  seg;
  logic [2:0]  dig_sel;
  logic        frame_done;
  display_pkg::state_t dbg_state;

  bcd_scan_display #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .ndigits    (ndigits),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int drv_cyc = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int          k = 0;
  logic [11:0] m_bcd = 12'd0;
  int          m_nd = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [W-1:0] model_out(input int cyc_k, input logic [11:0] v, input int nd);
    int p, s, c, d, masked;
    bit en, lz, show;
    p = cyc_k % FRAME;
    s = p / CLK_DIV;
    c = p % CLK_DIV;
    d = (int'(v) >> (4 * s)) & 15;
    en = (s < nd);
    masked = int'(v) & ((1 << (4 * nd)) - 1);
    lz = 1'b0;
`ifdef LZ_BLANK_EN
    lz = (s > 0) && ((masked >> (4 * s)) == 0);
`endif
    show = (c >= DEAD) && en && !lz;
    return {(p == FRAME - 1), (c >= DEAD), show ? 3'(1 << s) : 3'b000,
            show ? seg_of(d) : 7'h7F};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        k = 0;
        m_bcd = 12'd0;
        m_nd = 0;
      end else begin
        k++;
        exp_q.push_back(model_out(k, m_bcd, m_nd));
        if (k % FRAME == FRAME - 1) begin
          m_bcd = bcd;
          m_nd  = (ndigits > 8'd3) ? 3 : int'(ndigits);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] act, exp_v;
    forever begin
      @(negedge clk);
      act = {frame_done, (dbg_state == display_pkg::SHOW), dig_sel, seg};
      checks++;
      if (!rst_n) begin
        exp_v = {1'b0, 1'b0, 3'b000, 7'h7F};
        if (act !== exp_v) begin
          errors++;
          $display("FAIL reset t=%0t got fd/st/sel/seg=%03h want %03h", $time, act, exp_v);
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expect t=%0t got %03h", $time, act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL cycle k=%0d t=%0t got fd/st/sel/seg=%03h want %03h", k, $time, act, exp_v);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drv_cyc++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drv_cyc = 0;
  endtask

  task automatic set_in(input logic [11:0] b, input logic [7:0] n);
    bcd = b;
    ndigits = n;
  endtask

  initial begin
    rst_n = 1'b0;
    bcd = 12'h000;
    ndigits = 8'd0;
    repeat (3) @(posedge clk);
    release_reset();

    step(FRAME);                          // idle blank frame
    set_in(12'h123, 8'd3);  step(2 * FRAME);
    set_in(12'h005, 8'd1);  step(2 * FRAME);
    set_in(12'h005, 8'd200); step(2 * FRAME);
    set_in(12'h0A7, 8'd3);  step(FRAME + 12);
    set_in(12'h456, 8'd3);  step(2 * FRAME);  // mid-frame change
    set_in(12'h007, 8'd3);  step(2 * FRAME);
    set_in(12'h070, 8'd2);  step(2 * FRAME);

    // asynchronous reset at cycle 5 of slot 1
    while (drv_cyc % FRAME != CLK_DIV + 5) step(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    set_in(12'h987, 8'd3);
    release_reset();
    step(2 * FRAME);

    for (int it = 0; it < 40; it++) begin
      logic [11:0] b;
      for (int j = 0; j < 3; j++)
        b[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      set_in(b, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255))
                                            : 8'($urandom_range(0, 3)));
      step($urandom_range(1, 30));
    end
    step(FRAME);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
